// File: rtl/obi_mem_arbiter_pkg.sv
// obi_arb_pkg: shared source IDs, default widths and FIFO sizing helper for the OBI memory arbiter.
package obi_arb_pkg;
    typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} src_e;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/obi_mem_arbiter_if.sv
// obi_if: one req/gnt/rvalid bus; master drives the request, slave answers it.
interface obi_if #(
    parameter int ADDR_W = obi_arb_pkg::ADDR_W,
    parameter int DATA_W = obi_arb_pkg::DATA_W
);
    logic                req;
    logic                gnt;
    logic                rvalid;
    logic                we;
    logic [DATA_W/8-1:0] be;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rdata;
    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/obi_mem_arbiter_id_fifo.sv
// obi_id_fifo: small synchronous FIFO with full/empty flags and a combinational head.
module obi_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] slots [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = slots[rd_ptr];
    always_ff @(posedge clk_sys) begin
        if (do_push) slots[wr_ptr] <= din;
    end
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: shares one single-port RAM between the fetch and LSU OBI ports.
// Define OBI_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over instr.
module obi_mem_arbiter #(
    parameter int ADDR_W    = obi_arb_pkg::ADDR_W,
    parameter int DATA_W    = obi_arb_pkg::DATA_W,
    parameter int MAX_OUTST = 2
) (
    input  logic  clk_sys,
    input  logic  rst_sys,
    obi_if.slave  instr,
    obi_if.slave  data,
    obi_if.master mem,
    output logic  err_stray_rvalid
);
    import obi_arb_pkg::*;
    src_e sel, lock_src, pref;
    logic locked, sel_req, req_out, grant, rsp_ok, full, empty;
    logic head_id;
`ifdef OBI_ARB_RR_EN
    src_e rr_ptr;
    always_ff @(posedge clk_sys) begin
        if (rst_sys) rr_ptr <= SRC_INSTR;
        else if (grant) rr_ptr <= (sel == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    end
    assign pref = rr_ptr;
`else
    assign pref = SRC_DATA;
`endif
    // A locked selection is held until granted, so a stalled request is never switched.
    always_comb begin
        sel     = SRC_INSTR;
        sel_req = 1'b0;
        sel     = locked ? lock_src :
                  (instr.req && data.req) ? pref :
                  data.req ? SRC_DATA : SRC_INSTR;
        sel_req = (sel == SRC_DATA) ? data.req : instr.req;
    end
    assign req_out   = sel_req && !full && !rst_sys;
    assign grant     = req_out && mem.gnt;
    assign mem.req   = req_out;
    assign mem.we    = (sel == SRC_DATA) && data.we;
    assign mem.be    = (sel == SRC_DATA) ? data.be : '1;
    assign mem.addr  = (sel == SRC_DATA) ? data.addr : instr.addr;
    assign mem.wdata = (sel == SRC_DATA) ? data.wdata : '0;
    assign instr.gnt = grant && (sel == SRC_INSTR);
    assign data.gnt  = grant && (sel == SRC_DATA);
    assign rsp_ok       = mem.rvalid && !empty && !rst_sys;
    assign instr.rvalid = rsp_ok && (head_id == SRC_INSTR);
    assign data.rvalid  = rsp_ok && (head_id == SRC_DATA);
    assign instr.rdata  = mem.rdata;
    assign data.rdata   = mem.rdata;
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            locked           <= 1'b0;
            lock_src         <= SRC_INSTR;
            err_stray_rvalid <= 1'b0;
        end else begin
            locked   <= req_out && !mem.gnt;
            lock_src <= sel;
            if (mem.rvalid && empty) err_stray_rvalid <= 1'b1;
        end
    end
    obi_id_fifo #(.DEPTH(MAX_OUTST), .WIDTH(1)) u_id_fifo (
        .clk_sys (clk_sys),
        .rst_sys (rst_sys),
        .push    (grant),
        .pop     (rsp_ok),
        .din     (sel),
        .head    (head_id),
        .full    (full),
        .empty   (empty)
    );
endmodule
